// File: rtl/uart_var_rx_frame_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_var_rx_frame_if
//  Description : Serial-line / received-byte bundle for the variable-baud
//                UART frame receiver. The master drives the line and the bit
//                period; the slave (receiver) returns the byte and strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_var_rx_frame_if #(
    parameter int DIV_WIDTH = 16,
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic [DIV_WIDTH-1:0] baud_div;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output rx,
        output baud_div,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx,
        input  baud_div,
        output rx_data,
        output rx_valid,
        output frame_err,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_var_rx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : uart_var_rx_frame
//  Description : Variable-baud 8N1-style UART frame receiver. Synchronises the
//                raw line, detects the start edge, samples each bit at its
//                midpoint using a latched runtime bit period, and emits the
//                byte with a one-cycle valid strobe or a framing-error strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_var_rx_frame #(
    parameter int DIV_WIDTH = 16,
    parameter int DATA_BITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    uart_var_rx_frame_if.slave bus
);
    localparam int                   BIT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [DIV_WIDTH-1:0] MIN_DIV  = DIV_WIDTH'(4);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
    localparam logic [BIT_W-1:0]     LAST_BIT = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]     BIT_ONE  = BIT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t               state_q;
    logic                 rx_meta_q;
    logic                 rx_s_q;
    logic                 rx_prev_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [BIT_W-1:0]     bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 busy_q;

    logic [DIV_WIDTH-1:0] div_d;
    logic [DIV_WIDTH-1:0] cnt_start_d;
    logic                 start_d;
    logic                 sample_d;

    // Effective period (clamped to 4), half-bit preload, start edge and sample point.
    always_comb begin
        div_d       = (bus.baud_div < MIN_DIV) ? MIN_DIV : bus.baud_div;
        cnt_start_d = (div_d >> 1) - DIV_ONE;
        start_d     = (state_q == S_IDLE) && !rx_s_q && rx_prev_q;
        sample_d    = (cnt_q == '0);
    end

    // Two-flop synchroniser plus one flop of edge history, all idling high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // Frame FSM with bit timer; strobes default low and pulse for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            div_q       <= MIN_DIV;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;

            // Modulo bit timer: the zero cycle is the sample point, then reload.
            if (state_q == S_START || state_q == S_DATA || state_q == S_STOP) begin
                cnt_q <= sample_d ? (div_q - DIV_ONE) : (cnt_q - DIV_ONE);
            end

            case (state_q)
                S_IDLE: begin
                    if (start_d) begin
                        // Latch the period so mid-frame baud changes are ignored.
                        div_q   <= div_d;
                        cnt_q   <= cnt_start_d;
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (sample_d) begin
                        if (!rx_s_q) begin
                            bit_q   <= '0;
                            state_q <= S_DATA;
                        end else begin
                            // Line went back high before mid-start: glitch.
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (sample_d) begin
                        shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                        if (bit_q == LAST_BIT) begin
                            state_q <= S_STOP;
                        end else begin
                            bit_q <= bit_q + BIT_ONE;
                        end
                    end
                end
                S_STOP: begin
                    if (sample_d) begin
                        if (rx_s_q) begin
                            rx_data_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                            state_q    <= S_IDLE;
                            busy_q     <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    // Leave only once the line is high, so the held-low break
                    // cannot look like a fresh falling edge.
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;

endmodule
`default_nettype wire
